reset_release_sequencer: RTL
============================

# reset_release_sequencer

Reset-tree root block: asserts a bank of downstream resets asynchronously the moment `rst` rises, and releases them synchronously to `clk`. Release follows a fixed sequence: synchronizer settle, hold window, then staggered per-output deassertion. A synchronous software reset request replays the same hold-and-stagger sequence without an external reset. It sits between the raw chip/domain reset and the per-domain async-reset registers, so every async reset they see deasserts cleanly and in order.

## Interface
- `SYNC_STAGES`, default 3: synchronizer depth on `rst` deassertion; must be ≥2.
- `HOLD_CYCLES`, default 16: cycles all outputs stay asserted after the synchronizer clears; must be ≥1.
- `NUM_OUTS`, default 2: number of sequenced reset outputs; must be ≥1.
- `STAGGER`, default 4: cycles between successive output releases; must be ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sw_rst_req`  in  1  synchronous software reset request, level-sampled on `clk` edges.
- `test_mode`  in  1  scan bypass; when high, each `rst_out` bit equals `rst` combinationally.
- `rst_out`  out  NUM_OUTS  sequenced resets, active-high; bit 0 is released first.
- `ready`  out  1  high once all `rst_out` bits are deasserted.
- `busy`  out  1  high whenever the FSM is not in RUN.

## Operation
- While `rst`=1:
  - `rst_out` = all ones, `ready`=0, `busy`=1, asynchronously.
  - Synchronizer chain is set to all ones.
  - FSM is forced to HOLD with the counter at 0 and the output index at 0.
- Synchronizer: `SYNC_STAGES` flops, all async-set by `rst`, shifting in 0. Its output `sync_rst` holds the FSM and counters in reset.
- FSM states:
  - HOLD: counter increments each cycle. On reaching HOLD_CYCLES, release `rst_out[0]`. If NUM_OUTS=1 go to RUN, otherwise go to STAGGER with idx=1 and the counter cleared.
  - STAGGER: counter increments each cycle. On reaching STAGGER, release `rst_out[idx]` and clear the counter. If idx=NUM_OUTS-1 go to RUN, otherwise increment idx.
  - RUN: `ready`=1, `busy`=0.
- Software reset:
  - `sw_rst_req` sampled high in RUN sets all `rst_out` bits at that edge and clears `ready` at that edge.
  - The FSM then enters HOLD with the counter at 0 and idx at 0.
  - `sw_rst_req` is ignored in HOLD and STAGGER.
- `test_mode` affects only the output mux; the FSM keeps running underneath it.
- Counter width is clog2(max(HOLD_CYCLES, STAGGER)+1). The counter never wraps, because it is cleared on every release.

## Timing
- Edge numbering: edge n is the n-th rising `clk` edge strictly after `rst` falls.
- `sync_rst` falls at edge SYNC_STAGES.
- `rst_out[0]` falls at edge SYNC_STAGES+HOLD_CYCLES.
- `rst_out[i]` falls at edge SYNC_STAGES+HOLD_CYCLES+i·STAGGER.
- `ready` rises and `busy` falls on the same edge as the last `rst_out` release.
- Defaults: `rst_out[0]` falls at edge 19; `rst_out[1]`, `ready` and `busy` change at edge 23.
- Software request sampled at edge E:
  - `rst_out` goes all ones and `ready`=0 after edge E.
  - `rst_out[i]` falls at edge E+HOLD_CYCLES+i·STAGGER.
- `rst` reasserted mid-sequence: all outputs are immediately reset and the full sequence restarts from edge 0 after the next deassertion.
- A `rst` pulse shorter than one clock period still produces the full sequence.
- All `rst_out` bits come from flops; none is combinational except through the `test_mode` mux.

## Structure
- Package `reset_seq_pkg` holds:
  - state enum {HOLD, STAGGER, RUN};
  - counter width function;
  - parameter legality checks as elaboration-time assertions.
- Sub-module `reset_sync_chain`: a `SYNC_STAGES`-deep, async-set, shift-in-zero flop chain, reusable by other reset roots.

## Test plan
- Defaults: raise `rst` mid-cycle, drop it before an edge → `rst_out`=2'b11 immediately; `rst_out[0]` falls at edge 19; `rst_out[1]` and `ready` change at edge 23; `busy` falls at edge 23.
- Reassert `rst` at edge 20, then drop it → `rst_out`=2'b11 asynchronously and `ready`=0; the sequence restarts, with `rst_out[0]` falling 19 edges after the new deassertion.
- In RUN, pulse `sw_rst_req` for one cycle at edge E → `rst_out`=2'b11 after E; `rst_out[0]` falls at E+16; `rst_out[1]` and `ready` change at E+20.
- Hold `sw_rst_req` high during HOLD and STAGGER → no effect on release timing. Still high at RUN entry → a second sequence starts on the next edge.
- `test_mode`=1 → `rst_out` tracks `rst` combinationally in both directions. Switching `test_mode` to 0 in RUN → `rst_out`=0.
- NUM_OUTS=1, HOLD_CYCLES=1, SYNC_STAGES=2 → `rst_out[0]` and `ready` change at edge 3; STAGGER state is never entered.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset release sequencer.
package reset_seq_pkg;

  // Sequencer phases: all held, staggered release, fully released.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // The counter only needs to reach max(hold, stagger) because it clears on every release.
  function automatic int cnt_width(input int hold, input int stag);
    int m;
    m = (hold > stag) ? hold : stag;
    return (m + 1 > 2) ? $clog2(m + 1) : 1;
  endfunction

  // Legal parameter set. Each sequence needs at least a two-flop synchronizer and non-empty windows.
  function automatic bit params_ok(input int sync_stages, input int hold,
                                   input int num_outs, input int stag);
    return (sync_stages >= 2) && (hold >= 1) && (num_outs >= 1) && (stag >= 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert flop chain: set by rst, shifts in zeros on clk.
module reset_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst
);

  logic [STAGES-1:0] chain;

  // Set the whole chain immediately on rst and drain it with zeros afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], 1'b0};
  end

  assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset-tree root: asserts all downstream resets asynchronously, releases them
// synchronously after a hold window and then one at a time, spaced by STAGGER.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUTS    = 2,
  parameter int STAGGER     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
  input  logic                test_mode,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                ready,
  output logic                busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER);
  localparam int IW = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
  localparam logic [NUM_OUTS-1:0] ONE = NUM_OUTS'(1);

  if (!params_ok(SYNC_STAGES, HOLD_CYCLES, NUM_OUTS, STAGGER)) begin : g_bad_params
    $error("reset_release_sequencer: illegal parameter set");
  end

  logic                sync_rst;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [NUM_OUTS-1:0] rst_q;
  logic                ready_q;
  logic                busy_q;

  reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sync_rst (sync_rst)
  );

  // Release FSM; every output it drives is registered so downstream resets never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else if (sync_rst) begin
      state   <= ST_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            rst_q[0] <= 1'b0;
            cnt      <= '0;
            if (NUM_OUTS == 1) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state <= ST_STAGGER;
              idx   <= IW'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (cnt == CW'(STAGGER - 1)) begin
            rst_q <= rst_q & ~(ONE << idx);
            cnt   <= '0;
            if (idx == IW'(NUM_OUTS - 1)) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Software request replays hold + stagger; outputs assert on the sampling edge.
          if (sw_rst_req) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state   <= ST_HOLD;
          cnt     <= '0;
          idx     <= '0;
          rst_q   <= '1;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Scan bypass: only the output mux changes, the FSM keeps sequencing underneath.
  assign rst_out = test_mode ? {NUM_OUTS{rst}} : rst_q;
  assign ready   = ready_q;
  assign busy    = busy_q;

endmodule
